// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// ---------------------------------------------------------------------------
// bsg_manycore_pkt_encode_buffered
//
// Turns a core's 32-bit memory access into a manycore request packet and
// queues it toward the network. Local (non-remote) accesses are acknowledged
// at once and never enter the queue. Outstanding remote requests are tracked
// with a credit counter so the core can fence until all of its traffic has
// drained.
//
// Core address layout (MSB..LSB):
//   remote(1) | y_cord(y_cord_width_p) | x_cord(x_cord_width_p) | addr field
// The top bit of the addr field selects a special-op store (op=2'b10).
//
// Packet layout on data_o (MSB..LSB):
//   addr(addr_width_p) | op(2) | op_ex(data_width_p/8) | data(data_width_p)
//   | return_x | return_y | y_cord | x_cord
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   v_i / ready_o      core request handshake
//   addr_i, data_i,
//   mask_i, we_i       core access (we_i=1 store, 0 load)
//   fence_i            level; holds off new remote requests while high
//   my_x_i, my_y_i     own coordinates, sent as the return address
//   v_o / ready_i      packet handshake toward the network
//   data_o             packet at the head of the queue
//   credit_v_i         one outstanding request completed
//   out_credits_o      credits currently available
//   fence_busy_o       outstanding or queued traffic exists
//   error_o            one-cycle pulse after a rejected remote load
// ---------------------------------------------------------------------------
module bsg_manycore_pkt_encode_buffered #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 26,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 16,
  parameter bit load_enable_p     = 1'b1,
  parameter bit debug_p           = 1'b0,
  parameter int packet_width_lp   = addr_width_p + 2 + (data_width_p / 8) + data_width_p
                                    + 2 * (x_cord_width_p + y_cord_width_p),
  parameter int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [31:0]                 addr_i,
  input  logic [data_width_p-1:0]     data_i,
  input  logic [data_width_p/8-1:0]   mask_i,
  input  logic                        we_i,
  input  logic                        fence_i,
  input  logic [x_cord_width_p-1:0]   my_x_i,
  input  logic [y_cord_width_p-1:0]   my_y_i,

  output logic                        v_o,
  output logic [packet_width_lp-1:0]  data_o,
  input  logic                        ready_i,

  input  logic                        credit_v_i,
  output logic [credit_width_lp-1:0]  out_credits_o,
  output logic                        fence_busy_o,
  output logic                        error_o
);

  // Width of the address field below the coordinates, and of that field
  // once its special-op top bit is removed.
  localparam int field_width_lp = 32 - 1 - x_cord_width_p - y_cord_width_p;
  localparam int strip_width_lp = field_width_lp - 1;
  localparam int ptr_width_lp   = $clog2(fifo_els_p);
  localparam int count_width_lp = $clog2(fifo_els_p + 1);

  localparam logic [count_width_lp-1:0]  fifo_full_count = count_width_lp'(fifo_els_p);
  localparam logic [credit_width_lp-1:0] credit_max      = credit_width_lp'(max_out_credits_p);

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic                       remote;
  logic [y_cord_width_p-1:0]  y_cord;
  logic [x_cord_width_p-1:0]  x_cord;
  logic                       addr_top;
  logic [1:0]                 op;
  logic [addr_width_p-1:0]    pkt_addr;
  logic [packet_width_lp-1:0] packet;

  assign remote   = addr_i[31];
  assign y_cord   = addr_i[30 -: y_cord_width_p];
  assign x_cord   = addr_i[30 - y_cord_width_p -: x_cord_width_p];
  assign addr_top = addr_i[field_width_lp-1];

  always_comb begin
    op = 2'b00;
    if (we_i) begin
      op = addr_top ? 2'b10 : 2'b01;
    end
  end

  // The stripped address field is narrower or wider than the packet address
  // depending on the coordinate widths; fit it either way.
  generate
    if (strip_width_lp >= addr_width_p) begin : g_addr_trunc
      assign pkt_addr = addr_i[addr_width_p-1:0];
    end else begin : g_addr_zext
      assign pkt_addr = {{(addr_width_p - strip_width_lp){1'b0}}, addr_i[strip_width_lp-1:0]};
    end
  endgenerate

  assign packet = {pkt_addr, op, mask_i, data_i, my_x_i, my_y_i, y_cord, x_cord};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [packet_width_lp-1:0] mem [fifo_els_p];

  logic [ptr_width_lp-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [ptr_width_lp-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [count_width_lp-1:0]  count_reg, count_next;
  logic [credit_width_lp-1:0] credit_reg, credit_next;
  logic                       error_reg, error_next;

  logic fifo_full;
  logic fifo_empty;
  logic credit_at_max;
  logic remote_ready;
  logic handshake;
  logic reject;
  logic enq;
  logic deq;

  assign fifo_full     = (count_reg == fifo_full_count);
  assign fifo_empty    = (count_reg == '0);
  assign credit_at_max = (credit_reg == credit_max);

  // ready_o for remote traffic looks only at registered state, so a full
  // queue stays closed even in a cycle where the head is being dequeued.
  assign remote_ready = ~fifo_full & (credit_reg != '0) & ~fence_i;
  assign ready_o      = remote ? remote_ready : 1'b1;

  assign handshake = v_i & ready_o & remote;
  assign reject    = (load_enable_p == 1'b0) & ~we_i;
  assign enq       = handshake & ~reject;
  assign deq       = v_o & ready_i;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Depth is a power of two, so the pointers wrap on their own.
    wr_ptr_next = enq ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = deq ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    credit_next = credit_reg;
    if (enq && !credit_v_i) begin
      credit_next = credit_reg - 1'b1;
    end else if (credit_v_i && !enq && !credit_at_max) begin
      // A return with nothing outstanding is a protocol error upstream;
      // saturate rather than wrap.
      credit_next = credit_reg + 1'b1;
    end
  end

  assign error_next = handshake & reject;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      credit_reg <= credit_max;
      error_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      credit_reg <= credit_next;
      error_reg  <= error_next;
    end
  end

  // Packet storage carries no reset; its contents are only visible while
  // the queue is non-empty.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_ptr_reg] <= packet;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign v_o           = ~fifo_empty;
  assign data_o        = mem[rd_ptr_reg];
  assign out_credits_o = credit_reg;
  assign fence_busy_o  = ~credit_at_max | ~fifo_empty;
  assign error_o       = error_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (credit_v_i && !enq && credit_at_max) begin
        $error("%m: credit returned with no request outstanding");
      end
      if (debug_p && enq) begin
        $display("%m: enqueue x=%0d y=%0d op=%b addr=%h data=%h",
                 x_cord, y_cord, op, pkt_addr, data_i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_encode_buffered.sv
// Directed bench for bsg_manycore_pkt_encode_buffered. Instance A uses the
// default configuration (loads enabled, 16 credits); instance B rejects
// loads and has only 4 credits.
module tb_bsg_manycore_pkt_encode_buffered;

  logic        clk;
  logic        rst_n;
  logic [3:0]  my_x, my_y;
  logic [31:0] data;
  logic [3:0]  mask;

  logic        a_v, a_ready, a_we, a_fence, a_vo, a_rdy_net, a_credit_v, a_busy, a_err;
  logic [31:0] a_addr;
  logic [79:0] a_pkt;
  logic [4:0]  a_credits;

  logic        b_v, b_ready, b_we, b_fence, b_vo, b_rdy_net, b_credit_v, b_busy, b_err;
  logic [31:0] b_addr;
  logic [79:0] b_pkt;
  logic [2:0]  b_credits;

  int checks   = 0;
  int failures = 0;

  bsg_manycore_pkt_encode_buffered dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(a_v), .ready_o(a_ready), .addr_i(a_addr), .data_i(data), .mask_i(mask),
    .we_i(a_we), .fence_i(a_fence), .my_x_i(my_x), .my_y_i(my_y),
    .v_o(a_vo), .data_o(a_pkt), .ready_i(a_rdy_net),
    .credit_v_i(a_credit_v), .out_credits_o(a_credits),
    .fence_busy_o(a_busy), .error_o(a_err)
  );

  bsg_manycore_pkt_encode_buffered #(
    .load_enable_p(1'b0),
    .max_out_credits_p(4)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(b_v), .ready_o(b_ready), .addr_i(b_addr), .data_i(data), .mask_i(mask),
    .we_i(b_we), .fence_i(b_fence), .my_x_i(my_x), .my_y_i(my_y),
    .v_o(b_vo), .data_o(b_pkt), .ready_i(b_rdy_net),
    .credit_v_i(b_credit_v), .out_credits_o(b_credits),
    .fence_busy_o(b_busy), .error_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet fields: addr[79:54] op[53:52] op_ex[51:48] data[47:16]
  // ret_x[15:12] ret_y[11:8] y[7:4] x[3:0]
  function automatic logic [25:0] f_addr(input logic [79:0] p); return p[79:54]; endfunction
  function automatic logic [1:0]  f_op  (input logic [79:0] p); return p[53:52]; endfunction
  function automatic logic [3:0]  f_opex(input logic [79:0] p); return p[51:48]; endfunction
  function automatic logic [31:0] f_data(input logic [79:0] p); return p[47:16]; endfunction
  function automatic logic [3:0]  f_rx  (input logic [79:0] p); return p[15:12]; endfunction
  function automatic logic [3:0]  f_ry  (input logic [79:0] p); return p[11:8];  endfunction
  function automatic logic [3:0]  f_y   (input logic [79:0] p); return p[7:4];   endfunction
  function automatic logic [3:0]  f_x   (input logic [79:0] p); return p[3:0];   endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; my_x = 4'd1; my_y = 4'd0; data = '0; mask = 4'hF;
    a_v = 0; a_addr = '0; a_we = 1; a_fence = 0; a_rdy_net = 0; a_credit_v = 0;
    b_v = 0; b_addr = '0; b_we = 1; b_fence = 0; b_rdy_net = 0; b_credit_v = 0;

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_a_vo", a_vo, 0);
    chk("rst_a_credits", a_credits, 16);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_credits", b_credits, 4);
    chk("rst_b_vo", b_vo, 0);
    rst_n = 1'b1;
    tick();
    $display("step reset: done");

    // ---------------- T1: plain remote store ----------------
    a_addr = 32'h9180_0010; a_we = 1; mask = 4'hF; data = 32'hDEADBEEF; a_v = 1;
    #1 chk("t1_ready", a_ready, 1);
    tick(); a_v = 0;
    chk("t1_vo", a_vo, 1);
    chk("t1_op", f_op(a_pkt), 2'b01);
    chk("t1_opex", f_opex(a_pkt), 4'hF);
    chk("t1_data", f_data(a_pkt), 32'hDEADBEEF);
    chk("t1_x", f_x(a_pkt), 3);
    chk("t1_y", f_y(a_pkt), 2);
    chk("t1_rx", f_rx(a_pkt), 1);
    chk("t1_ry", f_ry(a_pkt), 0);
    chk("t1_addr", f_addr(a_pkt), 26'h10);
    chk("t1_credits", a_credits, 15);
    chk("t1_busy", a_busy, 1);
    a_rdy_net = 1;
    tick();
    chk("t1_drain_vo", a_vo, 0);
    $display("step t1 store: done");

    // ---------------- T2: special-op store ----------------
    a_addr = 32'h91C0_0123; data = 32'h1234_5678; a_v = 1;
    tick(); a_v = 0;
    chk("t2_op", f_op(a_pkt), 2'b10);
    chk("t2_addr", f_addr(a_pkt), 26'h123);
    chk("t2_credits", a_credits, 14);
    tick();
    $display("step t2 special store: done");

    // ---------------- T3: remote load, loads enabled ----------------
    a_addr = 32'h9180_0040; a_we = 0; a_v = 1;
    tick(); a_v = 0; a_we = 1;
    chk("t3_vo", a_vo, 1);
    chk("t3_op", f_op(a_pkt), 2'b00);
    chk("t3_addr", f_addr(a_pkt), 26'h40);
    chk("t3_credits", a_credits, 13);
    tick();
    a_credit_v = 1; tick(); tick(); tick(); a_credit_v = 0;
    chk("t3_ret_credits", a_credits, 16);
    chk("t3_ret_busy", a_busy, 0);
    $display("step t3 load: done");

    // ---------------- B: rejected load ----------------
    b_addr = 32'h9180_0040; b_we = 0; b_v = 1;
    #1 chk("rej_ready", b_ready, 1);
    tick(); b_v = 0; b_we = 1;
    chk("rej_err", b_err, 1);
    chk("rej_vo", b_vo, 0);
    chk("rej_credits", b_credits, 4);
    tick();
    chk("rej_err_end", b_err, 0);
    chk("rej_vo2", b_vo, 0);
    $display("step rejected load: done");

    // ---------------- back-pressure on A ----------------
    a_rdy_net = 0; a_addr = 32'h9180_0010; data = 32'h1111_1111; a_v = 1;
    tick(); data = 32'h2222_2222;
    tick(); data = 32'h3333_3333;
    #1 chk("bp_full_ready", a_ready, 0);
    chk("bp_head", f_data(a_pkt), 32'h1111_1111);
    tick();
    chk("bp_hold", f_data(a_pkt), 32'h1111_1111);
    chk("bp_hold_ready", a_ready, 0);
    a_rdy_net = 1;
    #1 chk("bp_full_deq_ready", a_ready, 0);
    tick(); a_rdy_net = 0;
    chk("bp_reassert", a_ready, 1);
    chk("bp_head2", f_data(a_pkt), 32'h2222_2222);
    tick(); a_v = 0;
    chk("bp_credits", a_credits, 13);
    a_rdy_net = 1;
    tick();
    chk("bp_head3", f_data(a_pkt), 32'h3333_3333);
    tick();
    chk("bp_drained", a_vo, 0);
    a_credit_v = 1; tick(); tick(); tick(); a_credit_v = 0;
    chk("bp_ret_credits", a_credits, 16);
    $display("step back-pressure: done");

    // ---------------- B: credit exhaustion ----------------
    b_rdy_net = 1; b_addr = 32'h9180_0010; b_we = 1; b_v = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cx_ready", b_ready, 1);
      tick();
    end
    chk("cx_zero_ready", b_ready, 0);
    chk("cx_zero_credits", b_credits, 0);
    tick();
    chk("cx_no_accept", b_credits, 0);
    b_v = 0; b_credit_v = 1;
    tick(); b_credit_v = 0;
    chk("cx_one_credit", b_credits, 1);
    b_v = 1;
    #1 chk("cx_one_ready", b_ready, 1);
    tick(); b_v = 0;
    chk("cx_used_again", b_credits, 0);
    b_v = 1;
    #1 chk("cx_blocked_again", b_ready, 0);
    b_v = 0;
    b_credit_v = 1;
    tick();
    b_v = 1;
    #1 chk("cx_coinc_ready", b_ready, 1);
    tick(); b_v = 0;
    chk("cx_coincident", b_credits, 1);
    tick(); tick(); tick(); b_credit_v = 0;
    chk("cx_full_return", b_credits, 4);
    chk("cx_busy", b_busy, 0);
    $display("step credit exhaustion: done");

    // ---------------- fence on A ----------------
    a_addr = 32'h9180_0010; a_v = 1;
    tick(); tick(); a_v = 0;
    tick();
    chk("fn_vo", a_vo, 0);
    chk("fn_credits", a_credits, 14);
    a_fence = 1; a_v = 1;
    #1 chk("fn_remote_ready", a_ready, 0);
    chk("fn_busy", a_busy, 1);
    a_addr = 32'h0000_0010;
    #1 chk("fn_local_ready", a_ready, 1);
    tick(); a_v = 0;
    chk("fn_local_credits", a_credits, 14);
    chk("fn_local_vo", a_vo, 0);
    a_credit_v = 1; tick(); tick(); a_credit_v = 0;
    chk("fn_idle_busy", a_busy, 0);
    chk("fn_idle_credits", a_credits, 16);
    a_fence = 0;
    $display("step fence: done");

    // ---------------- reset mid-stream on A ----------------
    a_addr = 32'h9180_0010; data = 32'h4444_4444; a_v = 1; a_rdy_net = 1;
    tick(); data = 32'h5555_5555;
    tick(); a_rdy_net = 0; data = 32'h6666_6666;
    tick(); a_v = 0;
    chk("mr_credits", a_credits, 13);
    chk("mr_vo", a_vo, 1);
    chk("mr_head", f_data(a_pkt), 32'h5555_5555);
    #2 rst_n = 1'b0;
    #1 chk("mr_async_vo", a_vo, 0);
    chk("mr_async_credits", a_credits, 16);
    chk("mr_async_busy", a_busy, 0);
    tick(); rst_n = 1'b1;
    tick();
    chk("mr_post_credits", a_credits, 16);
    chk("mr_post_vo", a_vo, 0);
    chk("mr_post_err", a_err, 0);
    data = 32'hCAFE_F00D; mask = 4'h3; a_v = 1;
    tick(); a_v = 0;
    chk("mr_pkt_vo", a_vo, 1);
    chk("mr_pkt_data", f_data(a_pkt), 32'hCAFE_F00D);
    chk("mr_pkt_opex", f_opex(a_pkt), 4'h3);
    chk("mr_pkt_x", f_x(a_pkt), 3);
    chk("mr_pkt_credits", a_credits, 15);
    $display("step reset mid-stream: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
